// File: rtl/demux1_to_4_reg_pkg.sv
// Shared types and constants for the registered 1-to-4 demux.
// Holds the steering-mode enumeration, channel count and pointer width.
package demux1_to_4_reg_pkg;

  localparam int NUM_CH = 4;
  localparam int PTR_W  = 2;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

endpackage

// File: rtl/demux1_to_4_reg_wrap_counter.sv
// Modulo-NUM_CH write pointer for round-robin steering.
// Ports: clk, rst (sync, high), enable (advance), clear (restart at 0),
// count (registered pointer), wrap (enable while count is at the last slot).
module wrap_counter
  import demux1_to_4_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [PTR_W-1:0] count,
  output logic             wrap
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CH - 1);

  // clear restarts the sequence; a same-edge enable then consumes slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= enable ? PTR_W'(1) : '0;
    end else if (enable) begin
      count <= count + PTR_W'(1);
    end
  end

  assign wrap = enable && !clear && (count == LAST);

endmodule

// File: rtl/demux1_to_4_reg.sv
// Registered 1-to-4 demux with manual (sel) or round-robin (auto) steering.
// Ports: clk, rst, in, in_valid, sel, auto_mode, clear -> out, out_valid,
// frame_valid, cnt. All outputs are registers.
module demux1_to_4_reg
  import demux1_to_4_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in,
  input  logic                    in_valid,
  input  logic [1:0]              sel,
  input  logic                    auto_mode,
  input  logic                    clear,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       out_valid,
  output logic                    frame_valid,
  output logic [PTR_W-1:0]        cnt
);

  mode_e             state;
  mode_e             next_state;
  logic              mode_chg;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [NUM_CH-1:0] wr_mask;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MANUAL;
    end else begin
      state <= next_state;
    end
  end

  // A write on a mode-change edge already uses the new mode; in auto it
  // lands in channel 0 because the partial frame is discarded.
  always_comb begin
    next_state = auto_mode ? AUTO : MANUAL;
    mode_chg   = (next_state != state);
    wr_en      = in_valid && !clear;
    wr_idx     = sel;
    if (next_state == AUTO) begin
      wr_idx = mode_chg ? '0 : cnt;
    end
    wr_mask = '0;
    if (wr_en) begin
      wr_mask = NUM_CH'(1) << wr_idx;
    end
    cnt_en  = wr_en && (next_state == AUTO);
    cnt_clr = clear || mode_chg;
  end

  wrap_counter u_wrap_counter (
    .clk    (clk),
    .rst    (rst),
    .enable (cnt_en),
    .clear  (cnt_clr),
    .count  (cnt),
    .wrap   (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out         <= '0;
      out_valid   <= '0;
      frame_valid <= 1'b0;
    end else begin
      out_valid   <= wr_mask;
      frame_valid <= cnt_wrap;
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_mask[k]) begin
          out[k*WIDTH +: WIDTH] <= in;
        end
      end
    end
  end

endmodule

// File: doc/demux1_to_4_reg.md
DEMUX1_TO_4_REG -- requirements
Module: demux1_to_4_reg

Interface
REQ-001 Parameter WIDTH, default 1: bit width of the input data and of each output channel.
REQ-002 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in  input  WIDTH  data to be steered to one channel.
REQ-005 in_valid  input  1  in is valid this cycle; write qualifier.
REQ-006 sel  input  2  destination channel in manual mode (0..3).
REQ-007 auto_mode  input  1  1 = round-robin steering by internal counter; 0 = steering by sel.
REQ-008 clear  input  1  synchronous flush of all channel registers and the counter.
REQ-009 out  output  4*WIDTH  channel registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  4  one-cycle pulse per channel: that channel was written on the previous edge.
REQ-011 frame_valid  output  1  one-cycle pulse: a full auto-mode frame (channels 0..3 in order) is complete in out.
REQ-012 cnt  output  2  current auto-mode write pointer, for debug and verification.

Function
REQ-013 The block SHALL have a 2-state FSM: MANUAL (auto_mode=0) and AUTO (auto_mode=1), with the state registered from auto_mode each cycle.
REQ-014 In MANUAL, on an edge with in_valid=1, out channel sel SHALL load in, and out_valid[sel] SHALL be 1 for the following cycle only.
REQ-015 In AUTO, on an edge with in_valid=1, out channel cnt SHALL load in, out_valid[cnt] SHALL pulse, and cnt SHALL increment modulo 4.
REQ-016 In AUTO, the write into channel 3 SHALL wrap cnt to 0 and SHALL pulse frame_valid in the same cycle that out_valid[3] pulses.
REQ-017 Write latency SHALL be one cycle: data presented at edge N is visible on out after edge N.
REQ-018 Channels not written on an edge SHALL hold their value; in_valid=0 SHALL change no out bits and no cnt.
REQ-019 frame_valid SHALL never pulse in MANUAL, and SHALL pulse only if channels 0,1,2,3 were written consecutively in AUTO without an intervening mode change or clear.
REQ-020 A transition MANUAL->AUTO or AUTO->MANUAL SHALL reset cnt to 0 at that edge, discarding any partial frame; channel contents are retained.
REQ-021 If auto_mode changes on the same edge as in_valid=1, the write SHALL use the new mode with cnt=0 (AUTO) or sel (MANUAL).
REQ-022 clear=1 SHALL zero out, cnt, out_valid and frame_valid at the next edge, and SHALL take priority over a simultaneous in_valid write.
REQ-023 sel SHALL be ignored in AUTO; in_valid=0 cycles SHALL not break frame continuity in AUTO.

Reset
REQ-024 On rst=1 at an edge: out=0, out_valid=0, frame_valid=0, cnt=0, and the FSM state SHALL be MANUAL regardless of auto_mode.
REQ-025 rst SHALL take priority over clear, in_valid and mode changes; rst mid-frame discards the partial frame with no frame_valid.
REQ-026 The first edge after rst deasserts SHALL evaluate auto_mode normally, with the mode-change rule of REQ-020 applied.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration (MANUAL, AUTO), the channel count constant (4) and the pointer width constant (2).
REQ-028 The modulo-4 write pointer SHALL be a sub-module named wrap_counter (enable, clear, 2-bit count, wrap pulse), instantiated once.
REQ-029 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Verification
REQ-030 Manual: WIDTH=1, auto_mode=0, in_valid=1, sel=2, in=1 -> next cycle out=4'b0100, out_valid=4'b0100, frame_valid=0.
REQ-031 Auto frame: auto_mode=1, four valid beats in=1,0,1,1 -> out=4'b1101, frame_valid pulses with out_valid[3], cnt=0 afterwards.
REQ-032 Auto gaps: beats 1,1 / idle 3 cycles / beats 0,1 -> one frame_valid, out=4'b1011.
REQ-033 Mode change mid-frame: two auto beats, then auto_mode=0 for one cycle, then auto_mode=1 -> cnt=0, no frame_valid until four fresh beats complete.
REQ-034 Clear vs write: clear=1 and in_valid=1 on the same edge -> out=0, out_valid=0, cnt=0.
REQ-035 Reset mid-frame: rst=1 after three auto beats -> all outputs 0, no frame_valid; the next four beats produce exactly one frame_valid.
